// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
//   Shared definitions for the RV decode stage: opcode constants, ALUOp
//   encodings, the decoded control bundle and the immediate format selector.
// -----------------------------------------------------------------------------
package decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUOp encodings handed to the EX-stage ALU controller
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IALU   = 2'b11;

  // Decoded control bundle
  typedef struct packed {
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Which immediate layout an opcode uses
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe_if
//   Bundles the IF/ID-side handshake, register-file read port, flush and the
//   EX-side payload of the decode stage.
//   slave  : the decode stage itself
//   master : its environment (IF/ID, register file, EX, hazard/flush control)
// -----------------------------------------------------------------------------
interface decode_stage_pipe_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);

  // IF/ID side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;

  // Register-file read port (combinational address -> same-cycle data)
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rf_rdata1;
  logic [XLEN-1:0]  rf_rdata2;

  // EX side
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_rs1_data;
  logic [XLEN-1:0]  out_rs2_data;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [9:0]       out_alu_ctrl;
  logic [1:0]       out_alu_op;
  logic             out_alusrc;
  logic             out_branch;
  logic             out_jump;
  logic             out_memread;
  logic             out_memwrite;
  logic             out_memtoreg;
  logic             out_regwrite;
  logic             out_illegal;
  logic [31:0]      out_instr;

  // Status
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, rf_rdata1, rf_rdata2, out_ready,
    output in_ready, rs1_addr, rs2_addr,
    output out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    output out_rd, out_rs1, out_rs2, out_alu_ctrl, out_alu_op,
    output out_alusrc, out_branch, out_jump, out_memread, out_memwrite,
    output out_memtoreg, out_regwrite, out_illegal, out_instr,
    output stall_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, rf_rdata1, rf_rdata2, out_ready,
    input  in_ready, rs1_addr, rs2_addr,
    input  out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    input  out_rd, out_rs1, out_rs2, out_alu_ctrl, out_alu_op,
    input  out_alusrc, out_branch, out_jump, out_memread, out_memwrite,
    input  out_memtoreg, out_regwrite, out_illegal, out_instr,
    input  stall_cnt
  );

endinterface

// File: rtl/rv_ctrl_decode.sv
// -----------------------------------------------------------------------------
// rv_ctrl_decode
//   Purely combinational RV opcode decoder.
//   i_instr    : 32-bit instruction word
//   o_ctrl     : control bundle (illegal set for unknown opcodes)
//   o_imm      : sign-extended immediate, XLEN wide (0 for R-type / illegal)
//   o_uses_rs1 : instruction reads rs1
//   o_uses_rs2 : instruction reads rs2
// -----------------------------------------------------------------------------
module rv_ctrl_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2
);

  imm_fmt_e w_fmt;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    o_ctrl     = CTRL_NOP;
    w_fmt      = IMM_NONE;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    unique case (i_instr[6:0])
      OP_R: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alu_op   = ALUOP_RTYPE;
        o_uses_rs1      = 1'b1;
        o_uses_rs2      = 1'b1;
      end
      OP_IMM: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.alu_op   = ALUOP_IALU;
        w_fmt           = IMM_I;
        o_uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.alu_op   = ALUOP_ADD;
        w_fmt           = IMM_I;
        o_uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
        o_ctrl.alu_op   = ALUOP_ADD;
        w_fmt           = IMM_S;
        o_uses_rs1      = 1'b1;
        o_uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_op   = ALUOP_BRANCH;
        w_fmt           = IMM_B;
        o_uses_rs1      = 1'b1;
        o_uses_rs2      = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.jump     = 1'b1;
        w_fmt           = IMM_J;
      end
      OP_JALR: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.jump     = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        w_fmt           = IMM_I;
        o_uses_rs1      = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.alusrc   = 1'b1;
        w_fmt           = IMM_U;
      end
      default: begin
        o_ctrl.illegal  = 1'b1;
      end
    endcase
  end

  // Immediate assembly; every format is sign-extended from instr[31].
  always_comb begin
    o_imm = '0;
    unique case (w_fmt)
      IMM_I: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      IMM_U: o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'h000};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe
//   RV decode stage plus ID/EX pipeline register with valid/ready handshake,
//   synchronous flush and a load-use interlock.
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : decode_stage_pipe_if.slave
//            in_valid/in_ready/in_instr/in_pc : IF/ID handshake
//            flush                            : kill entering and held instr
//            rs1_addr/rs2_addr, rf_rdata1/2   : register-file read port
//            out_valid/out_ready, out_*       : registered EX payload
//            stall_cnt                        : saturating load-use stalls
//   XLEN and CNT_W must match the parameters of the connected interface.
// -----------------------------------------------------------------------------
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  decode_stage_pipe_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;

  rv_ctrl_decode #(.XLEN(XLEN)) u_ctrl_decode (
    .i_instr    (bus.in_instr),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2)
  );

  // Unused source fields read x0 so the register file never sees junk
  // addresses (e.g. immediate bits of a LUI).
  assign w_rs1_addr   = w_uses_rs1 ? bus.in_instr[19:15] : 5'd0;
  assign w_rs2_addr   = w_uses_rs2 ? bus.in_instr[24:20] : 5'd0;
  assign bus.rs1_addr = w_rs1_addr;
  assign bus.rs2_addr = w_rs2_addr;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic             r_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic [9:0]       r_alu_ctrl;
  ctrl_t            r_ctrl;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_stall_cnt;

  // ---------------------------------------------------------------------------
  // Handshake and load-use interlock
  // ---------------------------------------------------------------------------
  logic w_load;
  logic w_hazard;
  logic w_in_ready;
  logic w_xfer;
  logic w_stall_evt;
  logic w_cnt_sat;

  // The register may take new data when it is empty or EX is draining it.
  assign w_load = !r_valid || bus.out_ready;

  // A load still sitting in ID/EX cannot forward to the instruction behind it;
  // rd=x0 never produces a value, so it never interlocks.
  assign w_hazard = bus.in_valid && r_valid && r_ctrl.memread && (r_rd != 5'd0) &&
                    ((w_uses_rs1 && (w_rs1_addr == r_rd)) ||
                     (w_uses_rs2 && (w_rs2_addr == r_rd)));

  assign w_in_ready   = w_load && !w_hazard && !bus.flush;
  assign w_xfer       = bus.in_valid && w_in_ready;
  assign bus.in_ready = w_in_ready;

  // Count only cycles where the stall actually costs a slot: the load is
  // leaving (out_ready) and a flush is not already discarding the work.
  assign w_stall_evt = w_hazard && bus.out_ready && !bus.flush;
  assign w_cnt_sat   = &r_stall_cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_alu_ctrl  <= '0;
      r_ctrl      <= CTRL_NOP;
      r_instr     <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Flush wins; otherwise a free slot either takes the transfer or
      // becomes a bubble. Without a free slot the valid bit holds.
      if (bus.flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= w_xfer;
      end

      // Payload moves only on a real transfer; during a bubble or flush the
      // data registers may keep stale contents behind out_valid=0.
      if (w_xfer) begin
        r_pc       <= bus.in_pc;
        r_rs1_data <= bus.rf_rdata1;
        r_rs2_data <= bus.rf_rdata2;
        r_imm      <= w_imm;
        r_rd       <= bus.in_instr[11:7];
        r_rs1      <= w_rs1_addr;
        r_rs2      <= w_rs2_addr;
        r_alu_ctrl <= {bus.in_instr[31:25], bus.in_instr[14:12]};
        r_ctrl     <= w_ctrl;
        r_instr    <= bus.in_instr;
      end

      if (w_stall_evt && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign bus.out_valid    = r_valid;
  assign bus.out_pc       = r_pc;
  assign bus.out_rs1_data = r_rs1_data;
  assign bus.out_rs2_data = r_rs2_data;
  assign bus.out_imm      = r_imm;
  assign bus.out_rd       = r_rd;
  assign bus.out_rs1      = r_rs1;
  assign bus.out_rs2      = r_rs2;
  assign bus.out_alu_ctrl = r_alu_ctrl;
  assign bus.out_alu_op   = r_ctrl.alu_op;
  assign bus.out_alusrc   = r_ctrl.alusrc;
  assign bus.out_branch   = r_ctrl.branch;
  assign bus.out_jump     = r_ctrl.jump;
  assign bus.out_memread  = r_ctrl.memread;
  assign bus.out_memwrite = r_ctrl.memwrite;
  assign bus.out_memtoreg = r_ctrl.memtoreg;
  assign bus.out_regwrite = r_ctrl.regwrite;
  assign bus.out_illegal  = r_ctrl.illegal;
  assign bus.out_instr    = r_instr;
  assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised successor to the current decode logic and ID/EX register. It decodes one RV instruction per cycle into control and immediate fields and widens everything to XLEN. The ID/EX register is wrapped in a valid/ready handshake with back-pressure, synchronous flush and a built-in load-use interlock. It sits between IF/ID and EX and drives the register-file read addresses directly.

Parameters:
XLEN, 64, datapath width of pc, register data and immediate
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts in_instr/in_pc this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  pc of in_instr
flush  in  1  kill the instruction entering and the one held
rs1_addr  out  5  combinational register-file read address 1
rs2_addr  out  5  combinational register-file read address 2
rf_rdata1  in  XLEN  register-file data for rs1_addr, same cycle
rf_rdata2  in  XLEN  register-file data for rs2_addr, same cycle
out_valid  out  1  EX-side payload valid
out_ready  in  1  EX accepts the payload
out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN each  registered payload
out_rd, out_rs1, out_rs2  out  5 each  registered register indices
out_alu_ctrl  out  10  {instr[31:25], instr[14:12]}
out_alu_op  out  2  00 add, 01 branch, 10 R-type, 11 I-ALU
out_alusrc, out_branch, out_jump, out_memread, out_memwrite, out_memtoreg, out_regwrite  out  1 each  control bits
out_illegal  out  1  opcode not recognised
out_instr  out  32  registered instruction
stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating

Behaviour:
- Reset: synchronous, active-high. One clock; reset is synchronous and active-high. On reset every registered output, including out_valid and stall_cnt, is set to 0.
- Decode (combinational on in_instr):
  - R (0110011): regwrite, alu_op=10.
  - I-ALU (0010011): regwrite, alusrc, alu_op=11.
  - LOAD (0000011): regwrite, alusrc, memread, memtoreg.
  - STORE (0100011): alusrc, memwrite.
  - BRANCH (1100011): branch, alu_op=01.
  - JAL (1101111): regwrite, jump.
  - JALR (1100111): regwrite, jump, alusrc.
  - LUI (0110111) and AUIPC (0010111): regwrite, alusrc.
  - Any other opcode: illegal=1 and all other control bits 0.
- Immediates: I/S/B/J/U immediates are sign-extended to XLEN. LUI and AUIPC place instr[31:12] at bits [31:12] and sign-extend from bit 31. Illegal opcodes and R-type produce imm=0.
- Register usage:
  - uses_rs1: every legal opcode except LUI, AUIPC and JAL.
  - uses_rs2: R, STORE and BRANCH only.
  - rs1_addr = instr[19:15] when used, else 0; rs2_addr likewise with instr[24:20]. Never X.
- Load enable: load = !out_valid || out_ready.
- hazard = in_valid && out_valid && out_memread && out_rd!=0 && ((uses_rs1 && rs1_addr==out_rd) || (uses_rs2 && rs2_addr==out_rd)).
- in_ready = load && !hazard && !flush. An input transfer occurs when in_valid && in_ready; the payload is captured next edge with 1-cycle latency.
- When load && !transfer, out_valid is cleared (bubble). When !load, all payload registers hold.
- Hazard with out_ready=1: a bubble is inserted, the input is held upstream, and it is accepted on the following cycle (the load has then left).
- stall_cnt increments on every cycle with hazard && out_ready, and saturates at all-ones.
- flush has priority over everything: next edge out_valid=0, and the incoming instruction is not accepted. The payload data registers may hold stale values.
- Illegal instructions are passed downstream with out_valid=1 and out_illegal=1. They are never dropped.
- Simultaneous flush and hazard: the flush wins, and stall_cnt does not increment.

Decomposition:
- decode_pkg holds:
  - the opcode localparams;
  - the ALUOp encodings;
  - a ctrl_t struct covering alusrc through illegal.
- One sub-module, rv_ctrl_decode: combinational opcode to ctrl_t, immediate, uses_rs1 and uses_rs2.
- The top level keeps the handshake, hazard logic, payload registers and counter.

Test Plan:
- Reset, then `add x3,x1,x2` (0x002081B3) with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_rd=3, out_regwrite=1, out_alu_op=10, out_alu_ctrl=10'b0000000000.
- `addi x5,x0,-1` (0xFFF00293) -> out_imm=64'hFFFF_FFFF_FFFF_FFFF, alusrc=1, alu_op=11, rs2_addr=0.
- `lw x5,0(x1)` followed by `add x6,x5,x2` -> in_ready=0 for one cycle, one bubble with out_valid=0, add issued the cycle after, stall_cnt=1.
- The same pair with rd=x0 (`lw x0`) -> no stall, stall_cnt stays 0.
- out_ready=0 for 3 cycles with a valid payload -> all out_* stable, in_ready=0; on release the next instruction follows with no loss or duplication.
- flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, instruction not consumed. Opcode 0x7F -> out_illegal=1, out_regwrite=0, out_valid=1.
